hex_display_pio: RTL
====================

Name: hex_display_pio

Overview:
- Parametrised Avalon-MM slave that drives NUM_DIGITS seven-segment displays directly from software-written nibbles.
- Adds the following on top of a plain output PIO:
  - per-digit enable (blanking) mask
  - per-digit hardware blink, with a programmable prescaler
  - atomic bit set/clear registers
  - an on-chip hex-to-segment decoder
- Sits in the SoC next to the other PIOs and feeds the HEX0..HEXn board pins.

Parameters:
- NUM_DIGITS, 4: number of digits, legal range 1..8. DATA_W = 4*NUM_DIGITS.
- BLINK_DIV, 25000000: clk cycles per blink half-period. Must be >= 2.
- ACTIVE_LOW, 1: 1 means a lit segment drives 0.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- address  in  3  register word offset
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data; zero-extended; 0-cycle read latency
- out_port  out  DATA_W  raw DATA register
- hex_segs  out  7*NUM_DIGITS  digit i at [7i+6:7i], bit order {g,f,e,d,c,b,a}
- blink_phase  out  1  current blink phase, for debug/LED

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. On reset:
  - DATA = 0
  - EN = all ones
  - BLINK = 0
  - blink counter = 0, phase = 0
  - readdata depends only on address, so reads 0 at offset 0 during reset.
  - hex_segs shows "0" on every digit; with ACTIVE_LOW=1 that is 7'h40 per digit.
- Write = chipselect & ~write_n, sampled at the clk rising edge. Takes effect the next cycle. Only writedata[DATA_W-1:0] or [NUM_DIGITS-1:0] is used; higher bits are ignored.
- Register map:
  - 0 DATA (RW): replaced by writedata.
  - 1 EN (RW): bit i = 1 means digit i is visible.
  - 2 BLINK (RW): bit i = 1 means digit i blinks. A write also clears the counter and phase to 0, so blinking digits are shown immediately.
  - 3 SET: a write does DATA |= wd. Reads return DATA.
  - 4 CLR: a write does DATA &= ~wd. Reads return DATA.
  - 5 STATUS (RO): bit0 = phase; bits [11:8] = NUM_DIGITS. Writes are ignored.
  - 6, 7: read 0, writes ignored.
- Read path: readdata is combinational on address. Unused bits are 0. It does not depend on chipselect, which keeps it side-effect free.
- Blink prescaler:
  - The counter counts 0..BLINK_DIV-1.
  - On the cycle it equals BLINK_DIV-1 it wraps to 0 and the phase toggles.
  - Width is clog2(BLINK_DIV).
  - Runs continuously, whether or not any BLINK bit is set.
- Digit i visible = EN[i] & ~(BLINK[i] & phase).
  - Visible: segments = decode(DATA[4i+3:4i]).
  - Not visible: all segments off (7'h7F when ACTIVE_LOW=1, 7'h00 otherwise).
- hex_segs is registered: one cycle after any register or phase change. out_port follows DATA with no extra delay.
- Simultaneous events: a BLINK write on the same cycle as a counter wrap means the write wins: counter = 0, phase = 0.
- Decode table, active high gfedcba:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - ACTIVE_LOW inverts.

Decomposition:
- Package hex_display_pkg holds:
  - register offset constants (REG_DATA=0 ... REG_STATUS=5)
  - the 16-entry segment constant table
  - SEG_OFF helper
- Sub-module hex_seg_decode: combinational nibble plus blank in, 7-bit segments out, honours ACTIVE_LOW. Instantiated NUM_DIGITS times via generate.

Test Plan (NUM_DIGITS=4, BLINK_DIV=4, ACTIVE_LOW=1):
- Reset, no writes:
  - hex_segs = 28'h8102040 (each digit 7'h40)
  - out_port = 0
  - read addr1 = 0xF, read addr5 = 0x400
- Write DATA=0x12AF:
  - next cycle out_port = 0x12AF
  - following cycle: digit0 = ~71, digit1 = ~77, digit2 = ~5B, digit3 = ~06 (7 bits)
  - read addr0 = 0x12AF
- Atomic update:
  - write SET=0x0F00, then read addr0 = 0x1FAF
  - write CLR=0x00FF, then read addr0 = 0x1F00
  - writedata bits above [15:0] have no effect
- EN=0x5: digits 1 and 3 show 7'h7F; digits 0 and 2 still decode.
- BLINK=0x1:
  - phase toggles every 4 cycles
  - digit0 alternates decoded/7'h7F with a 4-cycle half-period, lagging phase by one cycle
  - STATUS bit0 tracks phase
- Re-write BLINK on the cycle the counter is at 3: phase stays 0 and the counter restarts at 0.
- Assert reset_n mid-blink with DATA nonzero: all state returns to reset values asynchronously, and hex_segs shows all "0" digits.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display PIO: register offsets and the
// active-high gfedcba segment patterns for hex digits 0..F.
package hex_display_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_EN     = 3'd1;
  localparam logic [2:0] REG_BLINK  = 3'd2;
  localparam logic [2:0] REG_SET    = 3'd3;
  localparam logic [2:0] REG_CLR    = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  // Entry 15 is the most significant element, entry 0 the least.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_off(input bit active_low);
    return active_low ? 7'h7F : 7'h00;
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to seven-segment decoder with blanking.
// Output bit order is {g,f,e,d,c,b,a}.
module hex_seg_decode
  import hex_display_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] segs_o
);

  logic [6:0] lit;

  assign lit = SEG_TABLE[nibble_i];

  always_comb begin
    if (blank_i) begin
      segs_o = seg_off(ACTIVE_LOW);
    end else begin
      segs_o = ACTIVE_LOW ? ~lit : lit;
    end
  end

endmodule

// File: rtl/hex_display_pio.sv
// Avalon-MM seven-segment display PIO with per-digit enable, hardware blink
// and atomic set/clear access to the digit data register.
module hex_display_pio
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BLINK_DIV  = 25000000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [4*NUM_DIGITS-1:0] out_port,
  output logic [7*NUM_DIGITS-1:0] hex_segs,
  output logic                    blink_phase
);

  localparam int unsigned DataW = 4 * NUM_DIGITS;
  localparam int unsigned SegW  = 7 * NUM_DIGITS;
  localparam int unsigned CntW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CntW-1:0] CntMax  = CntW'(BLINK_DIV - 1);
  localparam logic [6:0]      SegZero = ACTIVE_LOW ? ~SEG_TABLE[0] : SEG_TABLE[0];

  logic [DataW-1:0]      data_q, data_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic [NUM_DIGITS-1:0] blink_q, blink_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [SegW-1:0]       segs_q, segs_d;
  logic [NUM_DIGITS-1:0] blank;

  logic                  wr_en;
  logic                  wrap;
  logic [DataW-1:0]      wd_data;
  logic [NUM_DIGITS-1:0] wd_mask;

  assign wr_en   = chipselect & ~write_n;
  assign wrap    = (cnt_q == CntMax);
  assign wd_data = writedata[DataW-1:0];
  assign wd_mask = writedata[NUM_DIGITS-1:0];

  always_comb begin
    data_d  = data_q;
    en_d    = en_q;
    blink_d = blink_q;
    cnt_d   = wrap ? '0 : cnt_q + CntW'(1);
    phase_d = phase_q ^ wrap;
    if (wr_en) begin
      case (address)
        REG_DATA: data_d = wd_data;
        REG_EN:   en_d   = wd_mask;
        REG_BLINK: begin
          // Restarting the prescaler makes newly blinking digits show at once,
          // and takes priority over a wrap on the same cycle.
          blink_d = wd_mask;
          cnt_d   = '0;
          phase_d = 1'b0;
        end
        REG_SET: data_d = data_q | wd_data;
        REG_CLR: data_d = data_q & ~wd_data;
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign blank[i] = ~en_q[i] | (blink_q[i] & phase_q);

    hex_seg_decode #(
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_dec (
      .nibble_i(data_q[4*i +: 4]),
      .blank_i (blank[i]),
      .segs_o  (segs_d[7*i +: 7])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      en_q    <= '1;
      blink_q <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      segs_q  <= {NUM_DIGITS{SegZero}};
    end else begin
      data_q  <= data_d;
      en_q    <= en_d;
      blink_q <= blink_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      segs_q  <= segs_d;
    end
  end

  // Read mux ignores chipselect so reads never have side effects.
  always_comb begin
    readdata = '0;
    case (address)
      REG_DATA, REG_SET, REG_CLR: readdata[DataW-1:0]      = data_q;
      REG_EN:                     readdata[NUM_DIGITS-1:0] = en_q;
      REG_BLINK:                  readdata[NUM_DIGITS-1:0] = blink_q;
      REG_STATUS: begin
        readdata[0]    = phase_q;
        readdata[11:8] = 4'(NUM_DIGITS);
      end
      default: ;
    endcase
  end

  assign out_port    = data_q;
  assign hex_segs    = segs_q;
  assign blink_phase = phase_q;

endmodule
